// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles the two requester ports and the RAM-side bus of mem_arbiter.
//
// Requester N (N = 0, 1):
//   rN_req, rN_we      request and write-select (requester -> arbiter)
//   rN_addr, rN_wdata  address and write data   (requester -> arbiter)
//   rN_gnt             request accepted this cycle (arbiter -> requester)
//   rN_rvalid, rN_rdata read return             (arbiter -> requester)
// RAM side:
//   mem_read_enable, mem_read_addr                    arbiter -> RAM
//   mem_write_enable, mem_write_addr, mem_write_data  arbiter -> RAM
//   mem_read_data  RAM -> arbiter, valid one cycle after mem_read_enable
//
// Modports: slave  = the arbiter's view
//           master = the environment's view (requesters plus RAM)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_read_enable, mem_write_enable,
        output mem_read_addr, mem_write_addr, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_read_enable, mem_write_enable,
        input  mem_read_addr, mem_write_addr, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter in front of a single-port-per-direction RAM with a
// one-cycle read latency. After reset the block waits for PLL lock, then
// counts WARMUP_CYCLES stable-lock cycles before it starts granting. Once
// running it stays running until reset, whatever pll_lock does.
//
// Grants are combinational: a requester that raises rN_req in RUN sees
// rN_gnt in the same cycle, and the RAM strobe for that transfer goes out in
// that same cycle. Read data comes back on the winner's rN_rvalid/rN_rdata one
// cycle later, passed straight through from mem_read_data.
//
// Ports:
//   clk       single clock, all state on the rising edge
//   resetq    asynchronous active-low reset
//   pll_lock  PLL lock indication
//   bus       mem_arbiter_if.slave (requester and RAM buses)
//   ready     high only while in RUN
//
// Parameters:
//   ADDR_W, DATA_W   address and data width
//   WARMUP_CYCLES    cycles spent in WARMUP before RUN (must be >= 1)
//
// Build option:
//   MEM_ARBITER_RR_EN  defined   -> round-robin on conflicts
//                      undefined -> requester 0 always wins a conflict
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WARMUP_CYCLES = 41
) (
    input  logic         clk,
    input  logic         resetq,
    input  logic         pll_lock,
    mem_arbiter_if.slave bus,
    output logic         ready
);

    // Wide enough to hold WARMUP_CYCLES-1 and always at least one bit.
    localparam int              CNT_W    = $clog2(WARMUP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        WARMUP,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // -----------------------------------------------------------------------
    // Startup FSM
    // -----------------------------------------------------------------------
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, exactly like the hardware.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (pll_lock) begin
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                // Losing lock always wins over finishing the warmup.
                if (!pll_lock) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Sticky until reset; pll_lock is deliberately ignored here.
                state_d = RUN;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    logic run;
    assign run   = (state_q == RUN);
    assign ready = run;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // Requests are masked outside RUN so grants and RAM strobes stay low
    // during startup and, via the async state reset, during reset too.
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;

    assign req0 = bus.r0_req & run;
    assign req1 = bus.r1_req & run;

`ifdef MEM_ARBITER_RR_EN
    // prefer1_q set means requester 1 wins the next conflict. It flips to
    // the other requester after every accepted transfer, so the requester
    // granted most recently loses a tie.
    logic prefer1_q;

    assign gnt0 = req0 & (~req1 | ~prefer1_q);
    assign gnt1 = req1 & (~req0 |  prefer1_q);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            prefer1_q <= 1'b0;
        end else if (gnt0) begin
            prefer1_q <= 1'b1;
        end else if (gnt1) begin
            prefer1_q <= 1'b0;
        end
    end
`else
    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
`endif

    assign bus.r0_gnt = gnt0;
    assign bus.r1_gnt = gnt1;

    // -----------------------------------------------------------------------
    // RAM request mux
    // -----------------------------------------------------------------------
    logic              any_gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              rd_en;
    logic              wr_en;

    assign any_gnt   = gnt0 | gnt1;
    assign win_we    = gnt1 ? bus.r1_we    : bus.r0_we;
    assign win_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign win_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;

    assign rd_en = any_gnt & ~win_we;
    assign wr_en = any_gnt &  win_we;

    assign bus.mem_read_enable  = rd_en;
    assign bus.mem_write_enable = wr_en;

    // Idle buses are forced to zero so the RAM side never sees stale values.
    assign bus.mem_read_addr  = rd_en ? win_addr  : '0;
    assign bus.mem_write_addr = wr_en ? win_addr  : '0;
    assign bus.mem_write_data = wr_en ? win_wdata : '0;

    // -----------------------------------------------------------------------
    // Read return
    // -----------------------------------------------------------------------
    // rd_pend_q marks that last cycle issued a read; rd_owner_q records who
    // issued it (0 = requester 0, 1 = requester 1). A new read can be issued
    // every cycle, so the pair is simply overwritten each cycle.
    logic rd_pend_q;
    logic rd_owner_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_en;
            if (rd_en) begin
                rd_owner_q <= gnt1;
            end
        end
    end

    logic rvalid0;
    logic rvalid1;

    assign rvalid0 = rd_pend_q & ~rd_owner_q;
    assign rvalid1 = rd_pend_q &  rd_owner_q;

    assign bus.r0_rvalid = rvalid0;
    assign bus.r1_rvalid = rvalid1;
    assign bus.r0_rdata  = rvalid0 ? bus.mem_read_data : '0;
    assign bus.r1_rdata  = rvalid1 ? bus.mem_read_data : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, width of requester and RAM address buses.
REQ-002 Parameter: DATA_W, default 16, width of requester and RAM data buses.
REQ-003 Parameter: WARMUP_CYCLES, default 41, clk cycles after PLL lock before any grant is issued.
REQ-004 Port: clk  input  1  single clock; all state on the rising edge.
REQ-005 Port: resetq  input  1  reset, asynchronous, active-low.
REQ-006 Port: pll_lock  input  1  PLL lock indication.
REQ-007 Ports: rN_req, rN_we  input  1 each  request and write-select for requester N (N = 0, 1).
REQ-008 Ports: rN_addr  input  ADDR_W, and rN_wdata  input  DATA_W  request address and write data.
REQ-009 Ports: rN_gnt  output  1  request accepted this cycle.
REQ-010 Ports: rN_rvalid  output  1, and rN_rdata  output  DATA_W  read return.
REQ-011 Ports: mem_read_enable, mem_write_enable  output  1 each  RAM strobes.
REQ-012 Ports: mem_read_addr, mem_write_addr  output  ADDR_W, and mem_write_data  output  DATA_W  RAM request buses.
REQ-013 Port: mem_read_data  input  DATA_W  RAM read data, valid one cycle after mem_read_enable.
REQ-014 Port: ready  output  1  high only in state RUN.

Function
REQ-015 FSM states: WAIT_LOCK, WARMUP, RUN.
REQ-016 WAIT_LOCK -> WARMUP when pll_lock = 1; warmup counter cleared on entry.
REQ-017 WARMUP: counter increments each cycle; when counter reaches WARMUP_CYCLES-1, FSM -> RUN on the next edge.
REQ-018 WARMUP with pll_lock = 0 -> WAIT_LOCK, counter cleared.
REQ-019 RUN is sticky; pll_lock ignored until reset.
REQ-020 Outside RUN: rN_gnt = 0 and both mem strobes = 0.
REQ-021 In RUN, rN_gnt is combinational in the same cycle as rN_req; at most one grant per cycle.
REQ-022 Transfer occurs when rN_req & rN_gnt; requester holds req, we, addr and wdata stable until granted.
REQ-023 Granted write: mem_write_enable = 1, mem_write_addr/mem_write_data = winner's addr/wdata, same cycle.
REQ-024 Granted read: mem_read_enable = 1, mem_read_addr = winner's addr, same cycle.
REQ-025 Read return: the winner's rN_rvalid pulses 1 cycle after the grant; rN_rdata = mem_read_data (combinational path).
REQ-026 Owner tag is registered at read grant; the other requester's rvalid stays 0.
REQ-027 Read latency is 1 cycle; back-to-back reads from either requester are accepted every cycle.
REQ-028 Single request: granted immediately, regardless of arbitration state.
REQ-029 Unused mem address/data buses drive 0 when their strobe is 0.

Reset
REQ-030 resetq low: FSM = WAIT_LOCK, counter = 0, RR pointer = requester 0 preferred, owner tag cleared, all rvalid = 0.
REQ-031 While resetq is low: all gnt, strobes and ready = 0 (asynchronous).
REQ-032 Reset asserted with a read in flight: the pending rvalid is dropped and not issued after reset release.

Configuration
REQ-033 Macro MEM_ARBITER_RR_EN defined: round-robin arbitration; on simultaneous requests, grant the requester not granted most recently; pointer updates on every accepted transfer.
REQ-034 Macro MEM_ARBITER_RR_EN undefined: fixed priority, requester 0 always wins a conflict; no pointer state.

Verification
REQ-035 Startup: resetq released; pll_lock=1 at cycle 5; r0_req held from cycle 0 -> r0_gnt=0 and ready=0 until cycle 5+41; first grant in that cycle, ready=1.
REQ-036 Lock glitch: pll_lock drops for 1 cycle in WARMUP at count 20 -> FSM returns to WAIT_LOCK; after relock a full 41-cycle warmup precedes the first grant.
REQ-037 Write then read: r1 writes 0xBEEF to 0x0123, then reads 0x0123 -> r1_rvalid one cycle after the read grant with r1_rdata=0xBEEF; r0_rvalid stays 0.
REQ-038 Contention with RR_EN: both requesters issue continuous reads -> grants alternate r0,r1,r0,r1; each rvalid one cycle after its own grant.
REQ-039 Contention without RR_EN: same stimulus -> r0 granted every cycle, r1_gnt=0 until r0_req drops, then r1 granted in the same cycle.
REQ-040 Reset mid-read: resetq low in the cycle after a granted read -> no rvalid on either requester, all outputs 0 during reset.
